// File: rtl/sprite_anim_seq.sv
// Per-player sprite animation sequencer: frame-tick timed state codes for the sprite ROM.
// Optional build macro ANIM_CANCEL_EN: attack/dir-start may be cancelled into block.
module sprite_anim_seq #(
  parameter int ATK_START_FR  = 5,
  parameter int ATK_END_FR    = 2,
  parameter int ATK_PULL_FR   = 16,
  parameter int DIR_START_FR  = 4,
  parameter int DIR_END_FR    = 3,
  parameter int DIR_PULL_FR   = 15,
  parameter int HIT_STUN_FR   = 16,
  parameter int BLOCK_STUN_FR = 8,
  parameter int CNT_W         = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       req_fwd,
  input  logic       req_back,
  input  logic       req_atk,
  input  logic       req_dir,
  input  logic       req_block,
  input  logic       hit_in,
  output logic [3:0] state,
  output logic       hit_active,
  output logic       busy,
  output logic       blocked
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_WALK   = 4'd1;
  localparam logic [3:0] S_BACK   = 4'd2;
  localparam logic [3:0] S_ASTART = 4'd3;
  localparam logic [3:0] S_AEND   = 4'd4;
  localparam logic [3:0] S_APULL  = 4'd5;
  localparam logic [3:0] S_DSTART = 4'd6;
  localparam logic [3:0] S_DEND   = 4'd7;
  localparam logic [3:0] S_DPULL  = 4'd8;
  localparam logic [3:0] S_GOTHIT = 4'd9;
  localparam logic [3:0] S_BLOCK  = 4'd10;

  logic [3:0]       state_q, state_d, free_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d, dur_m1;
  logic             hit_pend_q, hit_pend_d, hp;
  logic             armed_q, armed_d;
  logic             hit_active_q, hit_active_d, busy_q, busy_d, blocked_q, blocked_d;
  logic             restart, expired, blk_stun_done;

  always_comb begin
    // A hit arriving on the tick clk itself counts for that tick.
    hp = hit_pend_q | hit_in;

    if (hp)                        free_nxt = S_GOTHIT;
    else if (req_dir)              free_nxt = S_DSTART;
    else if (req_atk)              free_nxt = S_ASTART;
    else if (req_block)            free_nxt = S_BLOCK;
    else if (req_fwd && !req_back) free_nxt = S_WALK;
    else if (req_back && !req_fwd) free_nxt = S_BACK;
    else                           free_nxt = S_IDLE;

    case (state_q)
      S_ASTART: dur_m1 = CNT_W'(ATK_START_FR - 1);
      S_AEND:   dur_m1 = CNT_W'(ATK_END_FR - 1);
      S_APULL:  dur_m1 = CNT_W'(ATK_PULL_FR - 1);
      S_DSTART: dur_m1 = CNT_W'(DIR_START_FR - 1);
      S_DEND:   dur_m1 = CNT_W'(DIR_END_FR - 1);
      S_DPULL:  dur_m1 = CNT_W'(DIR_PULL_FR - 1);
      S_GOTHIT: dur_m1 = CNT_W'(HIT_STUN_FR - 1);
      default:  dur_m1 = CNT_W'(BLOCK_STUN_FR - 1);
    endcase
    expired       = (cnt_q == dur_m1);
    blk_stun_done = !armed_q || expired;

    state_d    = state_q;
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    hit_pend_d = hp;
    blocked_d  = 1'b0;
    restart    = 1'b0;

    if (frame_tick) begin
      hit_pend_d = 1'b0;
      case (state_q)
        S_ASTART, S_AEND, S_APULL, S_DSTART, S_DEND, S_DPULL: begin
          if (hp) state_d = S_GOTHIT;
`ifdef ANIM_CANCEL_EN
          else if (req_block && (state_q == S_ASTART || state_q == S_DSTART))
            state_d = S_BLOCK;
`endif
          else if (expired) begin
            case (state_q)
              S_ASTART: state_d = S_AEND;
              S_AEND:   state_d = S_APULL;
              S_DSTART: state_d = S_DEND;
              S_DEND:   state_d = S_DPULL;
              default:  state_d = free_nxt;
            endcase
          end
        end
        S_GOTHIT: begin
          if (hp)           restart = 1'b1;
          else if (expired) state_d = free_nxt;
        end
        S_BLOCK: begin
          if (hp) begin
            restart   = 1'b1;
            blocked_d = 1'b1;
            armed_d   = 1'b1;
          end else if (!req_block && blk_stun_done) begin
            state_d = free_nxt;
          end
        end
        default: state_d = free_nxt;
      endcase

      if (state_d != state_q || restart || state_d <= S_BACK)
        cnt_d = '0;
      else if (state_q == S_BLOCK && expired)
        cnt_d = cnt_q;
      else
        cnt_d = cnt_q + 1'b1;

      if (state_d != S_BLOCK || state_q != S_BLOCK) armed_d = armed_d && state_d == S_BLOCK
                                                              && state_q == S_BLOCK;
    end

    hit_active_d = (state_d == S_AEND) || (state_d == S_DEND);
    busy_d       = (state_d > S_BACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      hit_pend_q   <= 1'b0;
      armed_q      <= 1'b0;
      hit_active_q <= 1'b0;
      busy_q       <= 1'b0;
      blocked_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hit_pend_q   <= hit_pend_d;
      armed_q      <= armed_d;
      hit_active_q <= hit_active_d;
      busy_q       <= busy_d;
      blocked_q    <= blocked_d;
    end
  end

  assign state      = state_q;
  assign hit_active = hit_active_q;
  assign busy       = busy_q;
  assign blocked    = blocked_q;

endmodule
